// File: rtl/mem_bus_arbiter_if.sv
// Cache-side and AXI4 master-side channels of the memory bus arbiter.
// The arbiter takes the master modport; caches and memory sit on the slave side.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic              ic_ar_valid, ic_ar_ready, ic_r_valid, ic_r_ready, ic_r_last;
  logic [ADDR_W-1:0] ic_ar_addr;
  logic [LEN_W-1:0]  ic_ar_len;
  logic [DATA_W-1:0] ic_r_data;

  logic              dc_ar_valid, dc_ar_ready, dc_r_valid, dc_r_ready, dc_r_last;
  logic [ADDR_W-1:0] dc_ar_addr;
  logic [LEN_W-1:0]  dc_ar_len;
  logic [DATA_W-1:0] dc_r_data;

  logic                dc_aw_valid, dc_aw_ready, dc_w_valid, dc_w_ready, dc_w_last;
  logic [ADDR_W-1:0]   dc_aw_addr;
  logic [LEN_W-1:0]    dc_aw_len;
  logic [DATA_W-1:0]   dc_w_data;
  logic [DATA_W/8-1:0] dc_w_strb;
  logic                dc_b_valid, dc_b_ready;
  logic [1:0]          dc_b_resp;

  logic              m_ar_valid, m_ar_ready, m_ar_id;
  logic [ADDR_W-1:0] m_ar_addr;
  logic [LEN_W-1:0]  m_ar_len;
  logic              m_r_valid, m_r_ready, m_r_last;
  logic [DATA_W-1:0] m_r_data;

  logic                m_aw_valid, m_aw_ready;
  logic [ADDR_W-1:0]   m_aw_addr;
  logic [LEN_W-1:0]    m_aw_len;
  logic                m_w_valid, m_w_ready, m_w_last;
  logic [DATA_W-1:0]   m_w_data;
  logic [DATA_W/8-1:0] m_w_strb;
  logic                m_b_valid, m_b_ready;
  logic [1:0]          m_b_resp;

  modport master (
    input  ic_ar_valid, ic_ar_addr, ic_ar_len, ic_r_ready,
    output ic_ar_ready, ic_r_valid, ic_r_data, ic_r_last,
    input  dc_ar_valid, dc_ar_addr, dc_ar_len, dc_r_ready,
    output dc_ar_ready, dc_r_valid, dc_r_data, dc_r_last,
    input  dc_aw_valid, dc_aw_addr, dc_aw_len, dc_w_valid, dc_w_data, dc_w_strb, dc_w_last, dc_b_ready,
    output dc_aw_ready, dc_w_ready, dc_b_valid, dc_b_resp,
    output m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
    input  m_ar_ready, m_r_valid, m_r_data, m_r_last,
    output m_aw_valid, m_aw_addr, m_aw_len, m_w_valid, m_w_data, m_w_strb, m_w_last, m_b_ready,
    input  m_aw_ready, m_w_ready, m_b_valid, m_b_resp
  );

  modport slave (
    output ic_ar_valid, ic_ar_addr, ic_ar_len, ic_r_ready,
    input  ic_ar_ready, ic_r_valid, ic_r_data, ic_r_last,
    output dc_ar_valid, dc_ar_addr, dc_ar_len, dc_r_ready,
    input  dc_ar_ready, dc_r_valid, dc_r_data, dc_r_last,
    output dc_aw_valid, dc_aw_addr, dc_aw_len, dc_w_valid, dc_w_data, dc_w_strb, dc_w_last, dc_b_ready,
    input  dc_aw_ready, dc_w_ready, dc_b_valid, dc_b_resp,
    input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
    output m_ar_ready, m_r_valid, m_r_data, m_r_last,
    input  m_aw_valid, m_aw_addr, m_aw_len, m_w_valid, m_w_data, m_w_strb, m_w_last, m_b_ready,
    output m_aw_ready, m_w_ready, m_b_valid, m_b_resp
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one AXI4 master between ICache (read) and DCache (read/write): round-robin AR,
// one read burst in flight, DCache reads held off while a write is outstanding.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_bus_arbiter_if.master   bus,
  output logic                err_o
);
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_t;

  rd_state_t         r_rd_state, w_rd_next;
  wr_state_t         r_wr_state, w_wr_next;
  logic              r_gnt_dc, r_last_dc, r_err;
  logic [LEN_W-1:0]  r_len, r_cnt, r_aw_len;
  logic [ADDR_W-1:0] r_aw_addr;
  logic [DATA_W-1:0] w_r_data;
  logic              w_wr_pending, w_dc_elig, w_req, w_pick_dc, w_ar_hs, w_r_hs;

  // DCache reads wait while a write is queued or in flight (RAW ordering)
  assign w_wr_pending = (r_wr_state != W_IDLE) | bus.dc_aw_valid;
  assign w_dc_elig    = bus.dc_ar_valid & ~w_wr_pending;
  assign w_req        = bus.ic_ar_valid | w_dc_elig;
  assign w_pick_dc    = w_dc_elig & (~bus.ic_ar_valid | ~r_last_dc);
  assign w_ar_hs      = (r_rd_state == R_ADDR) & bus.m_ar_ready;
  assign w_r_hs       = (r_rd_state == R_DATA) & bus.m_r_valid & bus.m_r_ready;
  assign w_r_data     = bus.m_r_data;
  assign bus.ic_r_data = w_r_data;
  assign bus.dc_r_data = w_r_data;
  assign err_o        = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state <= R_IDLE;
      r_wr_state <= W_IDLE;
    end else begin
      r_rd_state <= w_rd_next;
      r_wr_state <= w_wr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_dc  <= 1'b0;
      r_last_dc <= 1'b1;
      r_len     <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_aw_addr <= '0;
      r_aw_len  <= '0;
    end else begin
      if ((r_rd_state == R_IDLE) && w_req) begin
        r_gnt_dc <= w_pick_dc;
        r_len    <= w_pick_dc ? bus.dc_ar_len : bus.ic_ar_len;
      end
      if (w_ar_hs) begin
        r_cnt     <= r_len;
        r_last_dc <= r_gnt_dc;
      end
      if (w_r_hs) begin
        r_cnt <= r_cnt - LEN_W'(1);
        if (bus.m_r_last != (r_cnt == '0)) r_err <= 1'b1;
      end
      if ((r_wr_state == W_IDLE) && bus.dc_aw_valid) begin
        r_aw_addr <= bus.dc_aw_addr;
        r_aw_len  <= bus.dc_aw_len;
      end
    end
  end

  always_comb begin
    w_rd_next       = r_rd_state;
    bus.m_ar_valid  = 1'b0;
    bus.m_ar_addr   = r_gnt_dc ? bus.dc_ar_addr : bus.ic_ar_addr;
    bus.m_ar_len    = r_gnt_dc ? bus.dc_ar_len  : bus.ic_ar_len;
    bus.m_ar_id     = r_gnt_dc;
    bus.ic_ar_ready = 1'b0;
    bus.dc_ar_ready = 1'b0;
    bus.ic_r_valid  = 1'b0;
    bus.dc_r_valid  = 1'b0;
    bus.ic_r_last   = 1'b0;
    bus.dc_r_last   = 1'b0;
    bus.m_r_ready   = 1'b0;
    case (r_rd_state)
      R_IDLE: if (w_req) w_rd_next = R_ADDR;
      R_ADDR: begin
        bus.m_ar_valid = 1'b1;
        if (bus.m_ar_ready) begin
          bus.ic_ar_ready = ~r_gnt_dc;
          bus.dc_ar_ready = r_gnt_dc;
          w_rd_next       = R_DATA;
        end
      end
      R_DATA: begin
        bus.ic_r_valid = bus.m_r_valid & ~r_gnt_dc;
        bus.dc_r_valid = bus.m_r_valid & r_gnt_dc;
        bus.ic_r_last  = bus.m_r_last & ~r_gnt_dc;
        bus.dc_r_last  = bus.m_r_last & r_gnt_dc;
        bus.m_r_ready  = r_gnt_dc ? bus.dc_r_ready : bus.ic_r_ready;
        // burst end follows the slave's last flag even when the count disagrees
        if (bus.m_r_valid && bus.m_r_ready && bus.m_r_last) w_rd_next = R_IDLE;
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_wr_next       = r_wr_state;
    bus.m_aw_valid  = 1'b0;
    bus.m_aw_addr   = r_aw_addr;
    bus.m_aw_len    = r_aw_len;
    bus.dc_aw_ready = 1'b0;
    bus.m_w_valid   = 1'b0;
    bus.m_w_data    = bus.dc_w_data;
    bus.m_w_strb    = bus.dc_w_strb;
    bus.m_w_last    = 1'b0;
    bus.dc_w_ready  = 1'b0;
    bus.dc_b_valid  = 1'b0;
    bus.dc_b_resp   = bus.m_b_resp;
    bus.m_b_ready   = 1'b0;
    case (r_wr_state)
      W_IDLE: if (bus.dc_aw_valid) w_wr_next = W_ADDR;
      W_ADDR: begin
        bus.m_aw_valid = 1'b1;
        if (bus.m_aw_ready) begin
          bus.dc_aw_ready = 1'b1;
          w_wr_next       = W_DATA;
        end
      end
      W_DATA: begin
        bus.m_w_valid  = bus.dc_w_valid;
        bus.m_w_last   = bus.dc_w_last;
        bus.dc_w_ready = bus.m_w_ready;
        if (bus.dc_w_valid && bus.m_w_ready && bus.dc_w_last) w_wr_next = W_RESP;
      end
      W_RESP: begin
        bus.dc_b_valid = bus.m_b_valid;
        bus.m_b_ready  = bus.dc_b_ready;
        if (bus.m_b_valid && bus.dc_b_ready) w_wr_next = W_IDLE;
      end
      default: w_wr_next = W_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a vector table for AR arbitration plus
// hand-written sequences for writes/RAW blocking, bad rlast, backpressure and reset.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic err_o;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .err_o(err_o)
  );

  typedef struct {
    logic       ic;
    logic       dc;
    logic [7:0] len;
    logic       exp_v;
    logic       exp_id;
  } vec_t;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    bus.ic_ar_valid = 1'b0; bus.ic_ar_addr = '0; bus.ic_ar_len = '0; bus.ic_r_ready = 1'b0;
    bus.dc_ar_valid = 1'b0; bus.dc_ar_addr = '0; bus.dc_ar_len = '0; bus.dc_r_ready = 1'b0;
    bus.dc_aw_valid = 1'b0; bus.dc_aw_addr = '0; bus.dc_aw_len = '0;
    bus.dc_w_valid  = 1'b0; bus.dc_w_data  = '0; bus.dc_w_strb = '0; bus.dc_w_last = 1'b0;
    bus.dc_b_ready  = 1'b0;
    bus.m_ar_ready  = 1'b0; bus.m_r_valid = 1'b0; bus.m_r_data = '0; bus.m_r_last = 1'b0;
    bus.m_aw_ready  = 1'b0; bus.m_w_ready = 1'b0; bus.m_b_valid = 1'b0; bus.m_b_resp = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    idle_inputs();
    tick(); tick();
    #1;
    chk32("rst_valids", {20'd0, bus.m_ar_valid, bus.m_aw_valid, bus.m_w_valid, bus.ic_r_valid,
                         bus.dc_r_valid, bus.dc_b_valid, bus.ic_ar_ready, bus.dc_ar_ready,
                         bus.dc_aw_ready, bus.dc_w_ready, bus.m_r_ready, bus.m_b_ready}, 32'd0);
    chk1("rst_err", err_o, 1'b0);
    chk32("rst_cnt", 32'(dut.r_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_rready(input logic id, input logic v);
    if (id) bus.dc_r_ready = v;
    else    bus.ic_r_ready = v;
  endtask

  // Entered at a negedge with the read FSM expected in R_ADDR; leaves it in R_DATA.
  task automatic expect_ar(input logic id, input logic [31:0] addr, input logic [7:0] len);
    #1;
    chk1("ar_valid", bus.m_ar_valid, 1'b1);
    chk1("ar_id", bus.m_ar_id, id);
    chk32("ar_addr", bus.m_ar_addr, addr);
    chk32("ar_len", 32'(bus.m_ar_len), 32'(len));
    bus.m_ar_ready = 1'b1;
    #1;
    chk1("ar_ready_owner", id ? bus.dc_ar_ready : bus.ic_ar_ready, 1'b1);
    chk1("ar_ready_other", id ? bus.ic_ar_ready : bus.dc_ar_ready, 1'b0);
    tick();
    bus.m_ar_ready = 1'b0;
    if (id) bus.dc_ar_valid = 1'b0;
    else    bus.ic_ar_valid = 1'b0;
  endtask

  // Slave returns beats 0..last_idx (m_r_last on last_idx); owner may stall before beat stall_at.
  task automatic serve_r(input logic id, input logic [7:0] len, input int last_idx,
                         input int stall_at, input int stall_n, input logic [31:0] base);
    logic [7:0] ec;
    for (int b = 0; b <= last_idx; b++) begin
      ec = len - 8'(b);
      bus.m_r_valid = 1'b1;
      bus.m_r_data  = base + 32'(b);
      bus.m_r_last  = (b == last_idx);
      if (b == stall_at) begin
        for (int s = 0; s < stall_n; s++) begin
          set_rready(id, 1'b0);
          #1;
          chk1("stall_m_r_ready", bus.m_r_ready, 1'b0);
          chk1("stall_r_valid", id ? bus.dc_r_valid : bus.ic_r_valid, 1'b1);
          chk32("stall_cnt", 32'(dut.r_cnt), 32'(ec));
          tick();
        end
      end
      set_rready(id, 1'b1);
      #1;
      chk1("r_valid_owner", id ? bus.dc_r_valid : bus.ic_r_valid, 1'b1);
      chk1("r_valid_other", id ? bus.ic_r_valid : bus.dc_r_valid, 1'b0);
      chk32("r_data", id ? bus.dc_r_data : bus.ic_r_data, base + 32'(b));
      chk1("r_last", id ? bus.dc_r_last : bus.ic_r_last, b == last_idx);
      chk32("r_cnt", 32'(dut.r_cnt), 32'(ec));
      tick();
    end
    bus.m_r_valid = 1'b0;
    bus.m_r_last  = 1'b0;
    set_rready(id, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    // last_grant entering the table is DCache
    vecs[0] = '{1'b1, 1'b1, 8'd0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 8'd1, 1'b1, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 8'd2, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 8'd0, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 8'd1, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 8'd0, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0};

    idle_inputs();
    do_reset();

    // ICache-only 4-beat burst
    bus.ic_ar_valid = 1'b1; bus.ic_ar_addr = 32'h1C00_0000; bus.ic_ar_len = 8'd3;
    #1 chk1("lat_ar_valid_n", bus.m_ar_valid, 1'b0);
    tick();
    expect_ar(1'b0, 32'h1C00_0000, 8'd3);
    serve_r(1'b0, 8'd3, 3, -1, 0, 32'hA000_0000);
    chk1("t1_err", err_o, 1'b0);

    // Simultaneous requests after reset: ICache first, then DCache after one idle cycle
    do_reset();
    bus.ic_ar_valid = 1'b1; bus.ic_ar_addr = 32'h1000_0040; bus.ic_ar_len = 8'd1;
    bus.dc_ar_valid = 1'b1; bus.dc_ar_addr = 32'h2000_0040; bus.dc_ar_len = 8'd0;
    tick();
    expect_ar(1'b0, 32'h1000_0040, 8'd1);
    serve_r(1'b0, 8'd1, 1, -1, 0, 32'hB000_0000);
    #1 chk1("gap_idle", bus.m_ar_valid, 1'b0);
    tick();
    expect_ar(1'b1, 32'h2000_0040, 8'd0);
    serve_r(1'b1, 8'd0, 0, -1, 0, 32'hB100_0000);

    for (int i = 0; i < 7; i++) begin
      bus.ic_ar_valid = vecs[i].ic; bus.ic_ar_addr = 32'h1000_0000 + 32'(i * 64); bus.ic_ar_len = vecs[i].len;
      bus.dc_ar_valid = vecs[i].dc; bus.dc_ar_addr = 32'h2000_0000 + 32'(i * 64); bus.dc_ar_len = vecs[i].len;
      tick();
      #1 chk1("tbl_ar_valid", bus.m_ar_valid, vecs[i].exp_v);
      if (vecs[i].exp_v) begin
        expect_ar(vecs[i].exp_id,
                  (vecs[i].exp_id ? 32'h2000_0000 : 32'h1000_0000) + 32'(i * 64), vecs[i].len);
        bus.ic_ar_valid = 1'b0; bus.dc_ar_valid = 1'b0;
        serve_r(vecs[i].exp_id, vecs[i].len, int'(vecs[i].len), -1, 0, 32'hC000_0000 + 32'(i << 8));
      end else begin
        tick();
        #1 chk1("tbl_no_grant", bus.m_ar_valid, 1'b0);
      end
    end

    // DCache write; DCache read blocked until B completes, ICache read passes
    bus.dc_aw_valid = 1'b1; bus.dc_aw_addr = 32'h3000_0040; bus.dc_aw_len = 8'd3;
    bus.dc_w_valid = 1'b1; bus.dc_w_data = 32'hDEAD_0000; bus.m_w_ready = 1'b1;
    #1;
    chk1("aw_idle_valid", bus.m_aw_valid, 1'b0);
    chk1("w_before_aw_idle", bus.m_w_valid, 1'b0);
    tick();
    #1;
    chk1("aw_valid", bus.m_aw_valid, 1'b1);
    chk32("aw_addr", bus.m_aw_addr, 32'h3000_0040);
    chk32("aw_len", 32'(bus.m_aw_len), 32'd3);
    chk1("w_before_aw", bus.m_w_valid, 1'b0);
    chk1("w_ready_before_aw", bus.dc_w_ready, 1'b0);
    bus.m_aw_ready = 1'b1;
    #1 chk1("dc_aw_ready", bus.dc_aw_ready, 1'b1);
    tick();
    bus.dc_aw_valid = 1'b0; bus.m_aw_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus.dc_w_valid = 1'b1; bus.dc_w_data = 32'hD000_0000 + 32'(b);
      bus.dc_w_strb = 4'hF ^ 4'(b); bus.dc_w_last = (b == 3);
      #1;
      chk1("w_valid", bus.m_w_valid, 1'b1);
      chk32("w_data", bus.m_w_data, 32'hD000_0000 + 32'(b));
      chk32("w_strb", 32'(bus.m_w_strb), 32'(4'hF ^ 4'(b)));
      chk1("w_last", bus.m_w_last, b == 3);
      chk1("dc_w_ready", bus.dc_w_ready, 1'b1);
      tick();
    end
    bus.dc_w_valid = 1'b0; bus.dc_w_last = 1'b0; bus.m_w_ready = 1'b0;
    bus.dc_b_ready = 1'b1;
    bus.dc_ar_valid = 1'b1; bus.dc_ar_addr = 32'h2000_0100; bus.dc_ar_len = 8'd0;
    bus.ic_ar_valid = 1'b1; bus.ic_ar_addr = 32'h1000_0100; bus.ic_ar_len = 8'd0;
    #1;
    chk1("b_valid_early", bus.dc_b_valid, 1'b0);
    chk1("raw_ar_idle", bus.m_ar_valid, 1'b0);
    tick();
    expect_ar(1'b0, 32'h1000_0100, 8'd0);
    serve_r(1'b0, 8'd0, 0, -1, 0, 32'hE000_0000);
    for (int k = 0; k < 3; k++) begin
      #1 chk1("raw_block", bus.m_ar_valid, 1'b0);
      tick();
    end
    bus.m_b_valid = 1'b1; bus.m_b_resp = 2'b01;
    #1;
    chk1("b_valid", bus.dc_b_valid, 1'b1);
    chk32("b_resp", 32'(bus.dc_b_resp), 32'd1);
    chk1("b_ready", bus.m_b_ready, 1'b1);
    chk1("raw_block_b", bus.m_ar_valid, 1'b0);
    tick();
    bus.m_b_valid = 1'b0; bus.m_b_resp = 2'b00; bus.dc_b_ready = 1'b0;
    #1 chk1("raw_grant_cycle", bus.m_ar_valid, 1'b0);
    tick();
    expect_ar(1'b1, 32'h2000_0100, 8'd0);
    serve_r(1'b1, 8'd0, 0, -1, 0, 32'hE100_0000);

    // Early rlast on beat 2 of a len=3 burst sets the sticky error
    chk1("err_before", err_o, 1'b0);
    bus.ic_ar_valid = 1'b1; bus.ic_ar_addr = 32'h1C00_0200; bus.ic_ar_len = 8'd3;
    tick();
    expect_ar(1'b0, 32'h1C00_0200, 8'd3);
    serve_r(1'b0, 8'd3, 1, -1, 0, 32'hF000_0000);
    #1;
    chk1("err_set", err_o, 1'b1);
    chk1("err_idle", bus.m_ar_valid, 1'b0);
    bus.ic_ar_valid = 1'b1; bus.ic_ar_addr = 32'h1C00_0300; bus.ic_ar_len = 8'd0;
    tick();
    expect_ar(1'b0, 32'h1C00_0300, 8'd0);
    serve_r(1'b0, 8'd0, 0, -1, 0, 32'hF100_0000);
    chk1("err_sticky", err_o, 1'b1);

    // DCache read with 3-cycle consumer stall before beat index 2
    bus.dc_ar_valid = 1'b1; bus.dc_ar_addr = 32'h2000_0400; bus.dc_ar_len = 8'd3;
    tick();
    expect_ar(1'b1, 32'h2000_0400, 8'd3);
    serve_r(1'b1, 8'd3, 3, 2, 3, 32'h5500_0000);
    #1 chk1("bp_done_idle", bus.m_ar_valid, 1'b0);

    // Asynchronous reset during R_DATA beat 2 and W_DATA
    bus.ic_ar_valid = 1'b1; bus.ic_ar_addr = 32'h1C00_0500; bus.ic_ar_len = 8'd3;
    bus.dc_aw_valid = 1'b1; bus.dc_aw_addr = 32'h3000_0500; bus.dc_aw_len = 8'd3;
    tick();
    #1;
    chk1("rst_t_ar_valid", bus.m_ar_valid, 1'b1);
    chk1("rst_t_aw_valid", bus.m_aw_valid, 1'b1);
    bus.m_ar_ready = 1'b1; bus.m_aw_ready = 1'b1;
    tick();
    bus.ic_ar_valid = 1'b0; bus.dc_aw_valid = 1'b0; bus.m_ar_ready = 1'b0; bus.m_aw_ready = 1'b0;
    bus.m_r_valid = 1'b1; bus.m_r_data = 32'h7700_0000; bus.ic_r_ready = 1'b1;
    bus.dc_w_valid = 1'b1; bus.dc_w_data = 32'h7800_0000; bus.m_w_ready = 1'b1;
    tick();
    bus.m_r_data = 32'h7700_0001; bus.dc_w_data = 32'h7800_0001;
    #1;
    chk1("pre_rst_r_valid", bus.ic_r_valid, 1'b1);
    chk1("pre_rst_w_valid", bus.m_w_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk32("async_rst_outs", {26'd0, bus.ic_r_valid, bus.m_w_valid, bus.dc_w_ready, bus.m_r_ready,
                             bus.m_ar_valid, bus.m_aw_valid}, 32'd0);
    chk32("async_rst_cnt", 32'(dut.r_cnt), 32'd0);
    chk1("async_rst_err", err_o, 1'b0);
    idle_inputs();
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk1("post_rst_ar", bus.m_ar_valid, 1'b0);
    chk1("post_rst_aw", bus.m_aw_valid, 1'b0);
    bus.ic_ar_valid = 1'b1; bus.ic_ar_addr = 32'h1C00_0600; bus.ic_ar_len = 8'd1;
    tick();
    expect_ar(1'b0, 32'h1C00_0600, 8'd1);
    serve_r(1'b0, 8'd1, 1, -1, 0, 32'h6600_0000);
    chk1("post_rst_err", err_o, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single AXI4 master port of the memory subsystem between the ICache (read-only) and the DCache (read and write).
- Sits between both caches and the top-level AXI4 master.
- Arbitrates the AR channel round-robin, with one read burst in flight at a time, and routes R beats back to the owner.
- Passes DCache write bursts through its own FSM and blocks DCache reads while a write is outstanding, to preserve RAW ordering.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data beat width
- LEN_W, 8, AXI burst length field width (beats = len+1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ic_ar_valid  in  1  ICache read request
- ic_ar_ready  out  1  ICache request accepted
- ic_ar_addr  in  ADDR_W  ICache read address
- ic_ar_len  in  LEN_W  ICache burst length
- ic_r_valid  out  1  ICache read beat valid
- ic_r_ready  in  1  ICache beat accept
- ic_r_data  out  DATA_W  ICache read data
- ic_r_last  out  1  ICache last beat
- dc_ar_valid, dc_ar_ready, dc_ar_addr, dc_ar_len, dc_r_valid, dc_r_ready, dc_r_data, dc_r_last  same as ICache set, for the DCache
- dc_aw_valid  in  1  DCache write address valid
- dc_aw_ready  out  1  DCache write address accepted
- dc_aw_addr  in  ADDR_W  DCache write address
- dc_aw_len  in  LEN_W  DCache write burst length
- dc_w_valid  in  1  DCache write beat valid
- dc_w_ready  out  1  DCache write beat accepted
- dc_w_data  in  DATA_W  DCache write data
- dc_w_strb  in  DATA_W/8  DCache write byte strobes
- dc_w_last  in  1  DCache last write beat
- dc_b_valid  out  1  write response valid
- dc_b_ready  in  1  write response accept
- dc_b_resp  out  2  write response code
- m_ar_valid, m_ar_ready, m_ar_addr, m_ar_len, m_ar_id(1)  master AR channel; id 0 = ICache, 1 = DCache
- m_r_valid, m_r_ready, m_r_data, m_r_last  master R channel
- m_aw_valid, m_aw_ready, m_aw_addr, m_aw_len  master AW channel
- m_w_valid, m_w_ready, m_w_data, m_w_strb, m_w_last  master W channel
- m_b_valid, m_b_ready, m_b_resp  master B channel
- err_o  out  1  sticky protocol error: R last-beat mismatch

Behaviour:
- Reset:
  - all valid/ready outputs 0; err_o 0.
  - read FSM R_IDLE, write FSM W_IDLE.
  - last_grant = DCache, so the ICache wins the first contention.
  - beat counter 0.

Read FSM (R_IDLE -> R_ADDR -> R_DATA -> R_IDLE):
- R_IDLE:
  - Eligible requesters: ic_ar_valid; dc_ar_valid & ~wr_pending.
  - One eligible: grant it. Both eligible: grant the requester other than last_grant.
  - Grant, len and id are registered; move to R_ADDR. No grant means stay.
- R_ADDR:
  - m_ar_valid=1; m_ar_addr/len driven combinationally from the granted requester, which must hold them stable.
  - On m_ar_ready: pulse the granted *_ar_ready for that same cycle, load beat counter = len, update last_grant, go to R_DATA.
- R_DATA:
  - m_r_valid goes to the owner's *_r_valid; m_r_ready = owner's *_r_ready; the non-owner's r_valid is 0.
  - Each handshake decrements the counter.
  - On a handshake with m_r_last=1, go to R_IDLE.
  - If m_r_last disagrees with counter==0 on any handshake, set err_o (sticky until reset). The FSM still follows m_r_last.
- Minimum latency: request in cycle N gives m_ar_valid in N+1. Back-to-back bursts have 1 idle cycle between the last R beat and the next m_ar_valid.

Write FSM (W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE):
- W_IDLE: on dc_aw_valid, register addr/len and go to W_ADDR.
- W_ADDR: m_aw_valid=1. On m_aw_ready, pulse dc_aw_ready and go to W_DATA.
- W_DATA: W channel passed through combinationally (m_w_* <= dc_w_*, dc_w_ready <= m_w_ready). On a handshake with dc_w_last, go to W_RESP.
- W_RESP: B channel passed through. On the m_b_valid & dc_b_ready handshake, go to W_IDLE.
- wr_pending = (write state != W_IDLE) | dc_aw_valid.
- Boundary rules:
  - A DCache read already in R_ADDR/R_DATA when an AW arrives completes normally; the write proceeds concurrently.
  - An ICache read is never blocked by writes.
  - W beats are never presented before the AW handshake.
  - Simultaneous ICache and DCache requests with last_grant=ICache: the DCache wins.
  - Reset mid-burst aborts both FSMs to idle immediately; there is no beat replay.

Test Plan:
- ic_ar_valid only, addr 0x1C000000, len 3, slave returns 4 beats with last on beat 4 -> m_ar_id=0, ic_r_valid 4 cycles, ic_r_last on beat 4, dc_r_valid=0 throughout, err_o=0.
- ic and dc ar_valid in the same cycle after reset -> ICache granted first; after its rlast, DCache is granted (m_ar_id=1) with exactly one R_IDLE cycle between.
- dc_aw_valid plus 4-beat write, then dc_ar_valid while B is pending -> m_ar_valid stays 0 until the cycle after the B handshake; ic_ar_valid in the same window is granted immediately.
- Slave asserts m_r_last on beat 2 of a len=3 burst -> err_o=1 and stays 1; read FSM returns to R_IDLE and the next request is served.
- m_r_ready backpressure: dc_r_ready held 0 for 3 cycles mid-burst -> no beat lost or duplicated, beat counter unchanged during the stall.
- rst_n asserted during R_DATA beat 2 and W_DATA -> all valids 0 asynchronously; after release both FSMs are idle and a fresh ICache request completes normally.
